// File: rtl/alu16_sequencer.sv
// Two-pass sequencer that runs 16-bit add, subtract and shift commands on an
// external 8-bit combinational ALU, carrying the inter-byte carry between passes.
module alu16_sequencer #(
    parameter logic [2:0] OP_OTYPE    = 3'b111,
    parameter logic [2:0] OP_ADD      = 3'b000,
    parameter logic [2:0] FN_SHIFTL_X = 3'b000,
    parameter logic [2:0] FN_SHIFTL_O = 3'b001,
    parameter logic [2:0] FN_SHIFTR_X = 3'b010,
    parameter logic [2:0] FN_SHIFTR_O = 3'b011
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  CMD,
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        hold,
    output logic [7:0]  ALU_A,
    output logic [7:0]  ALU_B,
    output logic [2:0]  ALU_OP,
    output logic [2:0]  ALU_FUNC,
    output logic        ALU_OVF_IN,
    input  logic [7:0]  ALU_OUT,
    input  logic        ALU_OVF_OUT,
    output logic        alu_req,
    output logic        busy,
    output logic        done,
    output logic [15:0] RESULT,
    output logic        CARRY_OUT
);

    localparam logic [1:0] CMD_ADD = 2'b00;
    localparam logic [1:0] CMD_SUB = 2'b01;
    localparam logic [1:0] CMD_SHL = 2'b10;
    localparam logic [1:0] CMD_SHR = 2'b11;

    typedef enum logic [1:0] {IDLE, P1, P2, DONE} state_t;

    state_t      state_q, state_d;
    logic [1:0]  cmd_q, cmd_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic        cy_q, cy_d;
    logic [7:0]  byte_q, byte_d;
    logic [15:0] result_q, result_d;
    logic        carry_q, carry_d;

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q  <= IDLE;
            cmd_q    <= 2'b00;
            a_q      <= 16'h0000;
            b_q      <= 16'h0000;
            cy_q     <= 1'b0;
            byte_q   <= 8'h00;
            result_q <= 16'h0000;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cy_q     <= cy_d;
            byte_q   <= byte_d;
            result_q <= result_d;
            carry_q  <= carry_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        a_d      = a_q;
        b_d      = b_q;
        cy_d     = cy_q;
        byte_d   = byte_q;
        result_d = result_q;
        carry_d  = carry_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cmd_d   = CMD;
                    a_d     = A;
                    b_d     = B;
                    state_d = P1;
                end
            end
            P1: begin
                if (!hold) begin
                    byte_d  = ALU_OUT;
                    cy_d    = ALU_OVF_OUT;
                    state_d = P2;
                end
            end
            P2: begin
                if (!hold) begin
                    // Right shifts process the high byte first, so pass 1 holds the upper half.
                    if (cmd_q == CMD_SHR) begin
                        result_d = {byte_q, ALU_OUT};
                    end else begin
                        result_d = {ALU_OUT, byte_q};
                    end
                    carry_d = ALU_OVF_OUT;
                    cy_d    = ALU_OVF_OUT;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ALU drive depends only on state and latched operands, so it is steady across holds.
    always_comb begin
        ALU_A      = 8'h00;
        ALU_B      = 8'h00;
        ALU_OP     = 3'b000;
        ALU_FUNC   = 3'b000;
        ALU_OVF_IN = 1'b0;
        if (state_q == P1 || state_q == P2) begin
            case (cmd_q)
                CMD_ADD: begin
                    ALU_OP     = OP_ADD;
                    ALU_A      = (state_q == P1) ? a_q[7:0] : a_q[15:8];
                    ALU_B      = (state_q == P1) ? b_q[7:0] : b_q[15:8];
                    ALU_OVF_IN = (state_q == P1) ? 1'b0 : cy_q;
                end
                CMD_SUB: begin
                    ALU_OP     = OP_ADD;
                    ALU_A      = (state_q == P1) ? a_q[7:0] : a_q[15:8];
                    ALU_B      = (state_q == P1) ? ~b_q[7:0] : ~b_q[15:8];
                    ALU_OVF_IN = (state_q == P1) ? 1'b1 : cy_q;
                end
                CMD_SHL: begin
                    ALU_OP     = OP_OTYPE;
                    ALU_A      = (state_q == P1) ? a_q[7:0] : a_q[15:8];
                    ALU_FUNC   = (state_q == P1) ? FN_SHIFTL_X : FN_SHIFTL_O;
                    ALU_OVF_IN = (state_q == P1) ? 1'b0 : cy_q;
                end
                CMD_SHR: begin
                    ALU_OP     = OP_OTYPE;
                    ALU_A      = (state_q == P1) ? a_q[15:8] : a_q[7:0];
                    ALU_FUNC   = (state_q == P1) ? FN_SHIFTR_X : FN_SHIFTR_O;
                    ALU_OVF_IN = (state_q == P1) ? 1'b0 : cy_q;
                end
                default: begin
                    ALU_OP = OP_ADD;
                end
            endcase
        end
    end

    assign busy      = (state_q == P1) || (state_q == P2);
    assign alu_req   = busy;
    assign done      = (state_q == DONE);
    assign RESULT    = result_q;
    assign CARRY_OUT = carry_q;

endmodule

// File: tb/tb_alu16_sequencer.sv
// Randomised bench for alu16_sequencer: an 8-bit ALU model closes the loop and a
// command-level model predicts busy/done timing, drives and 16-bit results.
module tb_alu16_sequencer;

    localparam logic [2:0] OP_OTYPE    = 3'b111;
    localparam logic [2:0] OP_ADD      = 3'b000;
    localparam logic [2:0] FN_SHIFTL_X = 3'b000;
    localparam logic [2:0] FN_SHIFTL_O = 3'b001;
    localparam logic [2:0] FN_SHIFTR_X = 3'b010;
    localparam logic [2:0] FN_SHIFTR_O = 3'b011;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  CMD = 2'b00;
    logic [15:0] A = 16'h0000;
    logic [15:0] B = 16'h0000;
    logic        hold = 1'b0;
    logic [7:0]  ALU_A, ALU_B, ALU_OUT;
    logic [2:0]  ALU_OP, ALU_FUNC;
    logic        ALU_OVF_IN, ALU_OVF_OUT;
    logic        alu_req, busy, done, CARRY_OUT;
    logic [15:0] RESULT;

    int assertCount = 0;
    int failCount = 0;
    int doneCount = 0;
    bit checkEn = 1'b0;

    alu16_sequencer #(.OP_OTYPE(OP_OTYPE)) dut (
        .CLK(CLK), .reset(reset), .start(start), .CMD(CMD), .A(A), .B(B), .hold(hold),
        .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_OP(ALU_OP), .ALU_FUNC(ALU_FUNC),
        .ALU_OVF_IN(ALU_OVF_IN), .ALU_OUT(ALU_OUT), .ALU_OVF_OUT(ALU_OVF_OUT),
        .alu_req(alu_req), .busy(busy), .done(done), .RESULT(RESULT), .CARRY_OUT(CARRY_OUT)
    );

    always #5 CLK = ~CLK;

    // Behaviour of the core's 8-bit ALU for the opcodes the sequencer uses.
    function automatic logic [8:0] aluModel(input logic [7:0] a, input logic [7:0] b,
                                            input logic [2:0] op, input logic [2:0] fn,
                                            input logic ci);
        logic [8:0] r;
        r = 9'h000;
        if (op == OP_ADD) begin
            r = {1'b0, a} + {1'b0, b} + {8'h00, ci};
        end else if (op == OP_OTYPE) begin
            case (fn)
                FN_SHIFTL_X: r = {a[7], a[6:0], 1'b0};
                FN_SHIFTL_O: r = {a[7], a[6:0], ci};
                FN_SHIFTR_X: r = {a[0], 1'b0, a[7:1]};
                FN_SHIFTR_O: r = {a[0], ci, a[7:1]};
                default:     r = 9'h000;
            endcase
        end
        return r;
    endfunction

    assign {ALU_OVF_OUT, ALU_OUT} = aluModel(ALU_A, ALU_B, ALU_OP, ALU_FUNC, ALU_OVF_IN);

    // Command-level model: passes remaining, pending done, and the architectural result.
    int          passesLeft = 0;
    bit          doneExp = 1'b0;
    logic [1:0]  mCmd = 2'b00;
    logic [15:0] mA = 16'h0000;
    logic [15:0] mB = 16'h0000;
    logic [15:0] expResult = 16'h0000;
    logic        expCarry = 1'b0;

    function automatic logic [16:0] golden(input logic [1:0] c, input logic [15:0] a,
                                           input logic [15:0] b);
        case (c)
            2'b00:   return {1'b0, a} + {1'b0, b};
            2'b01:   return {(a >= b), a - b};
            2'b10:   return {a[15], a << 1};
            default: return {a[0], a >> 1};
        endcase
    endfunction

    // Expected {ALU_A, ALU_B, ALU_OP, ALU_FUNC, ALU_OVF_IN} from the command table.
    function automatic logic [22:0] expDrive();
        logic       p2;
        logic       lowCarry;
        p2 = (passesLeft == 1);
        lowCarry = golden(2'b00, {8'h00, mA[7:0]}, {8'h00, mB[7:0]}) >> 8;
        if (passesLeft == 0) return 23'h0;
        case (mCmd)
            2'b00: return p2 ? {mA[15:8], mB[15:8], OP_ADD, 3'b000, lowCarry}
                             : {mA[7:0], mB[7:0], OP_ADD, 3'b000, 1'b0};
            2'b01: return p2 ? {mA[15:8], ~mB[15:8], OP_ADD, 3'b000, (mA[7:0] >= mB[7:0])}
                             : {mA[7:0], ~mB[7:0], OP_ADD, 3'b000, 1'b1};
            2'b10: return p2 ? {mA[15:8], 8'h00, OP_OTYPE, FN_SHIFTL_O, mA[7]}
                             : {mA[7:0], 8'h00, OP_OTYPE, FN_SHIFTL_X, 1'b0};
            default: return p2 ? {mA[7:0], 8'h00, OP_OTYPE, FN_SHIFTR_O, mA[8]}
                               : {mA[15:8], 8'h00, OP_OTYPE, FN_SHIFTR_X, 1'b0};
        endcase
    endfunction

    always @(posedge CLK) begin
        if (reset) begin
            passesLeft = 0;
            doneExp    = 1'b0;
            expResult  = 16'h0000;
            expCarry   = 1'b0;
        end else if (doneExp) begin
            doneExp = 1'b0;
        end else if (passesLeft > 0) begin
            if (!hold) begin
                passesLeft = passesLeft - 1;
                if (passesLeft == 0) begin
                    doneExp = 1'b1;
                    {expCarry, expResult} = golden(mCmd, mA, mB);
                end
            end
        end else if (start) begin
            mCmd = CMD;
            mA = A;
            mB = B;
            passesLeft = 2;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge CLK) begin
        if (checkEn) begin
            check("busy", {31'b0, busy}, {31'b0, passesLeft > 0});
            check("alu_req", {31'b0, alu_req}, {31'b0, passesLeft > 0});
            check("done", {31'b0, done}, {31'b0, doneExp});
            check("RESULT", {16'b0, RESULT}, {16'b0, expResult});
            check("CARRY_OUT", {31'b0, CARRY_OUT}, {31'b0, expCarry});
            check("drive", {9'b0, ALU_A, ALU_B, ALU_OP, ALU_FUNC, ALU_OVF_IN}, {9'b0, expDrive()});
            if (done) doneCount++;
        end
    end

    logic [15:0] lastResult;
    logic        lastCarry;
    int          lastLatency;
    int          lastBusy;
    int          lastDones;

    // Launch one command; holdMask bit i drives hold in the i-th cycle after the start edge.
    task automatic applyStimulus(input logic [1:0] c, input logic [15:0] a, input logic [15:0] b,
                                 input logic [7:0] holdMask, input bit extraStart);
        logic [7:0] mask;
        int cyc;
        int dones0;
        bit seen;
        mask = holdMask;
        seen = 1'b0;
        lastBusy = 0;
        lastLatency = 0;
        dones0 = doneCount;
        @(posedge CLK); #2;
        start = 1'b1; CMD = c; A = a; B = b; hold = 1'b0;
        @(posedge CLK); #2;
        cyc = 1;
        while (!seen && cyc <= 20) begin
            start = extraStart && (cyc == 2);
            hold = mask[0];
            mask = mask >> 1;
            @(negedge CLK);
            if (busy) lastBusy++;
            if (done) begin
                seen = 1'b1;
                lastLatency = cyc;
                lastResult = RESULT;
                lastCarry = CARRY_OUT;
            end
            if (!seen) begin
                @(posedge CLK); #2;
                cyc++;
            end
        end
        start = 1'b0;
        hold = 1'b0;
        if (!seen) check("done timeout", 32'd0, 32'd1);
        @(posedge CLK); #2;
        lastDones = doneCount - dones0;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] r, input logic co,
                               input int latency, input int busyCycles);
        check({name, " result"}, {16'b0, lastResult}, {16'b0, r});
        check({name, " carry"}, {31'b0, lastCarry}, {31'b0, co});
        if (latency > 0) check({name, " latency"}, latency, lastLatency);
        if (busyCycles > 0) check({name, " busy cycles"}, busyCycles, lastBusy);
        check({name, " done count"}, lastDones, 32'd1);
    endtask

    initial begin
        int d0;
        reset = 1'b1;
        @(posedge CLK); #2;
        checkEn = 1'b1;
        @(negedge CLK);
        check("reset RESULT", {16'b0, RESULT}, 32'h0);
        check("reset busy/done", {30'b0, busy, done}, 32'h0);
        check("reset drives", {9'b0, ALU_A, ALU_B, ALU_OP, ALU_FUNC, ALU_OVF_IN}, 32'h0);
        @(posedge CLK); #2;
        reset = 1'b0;

        applyStimulus(2'b00, 16'h00FF, 16'h0001, 8'h00, 1'b0);
        checkOutput("add 00FF+0001", 16'h0100, 1'b0, 3, 2);
        applyStimulus(2'b00, 16'hFFFF, 16'h0001, 8'h00, 1'b0);
        checkOutput("add FFFF+0001", 16'h0000, 1'b1, 3, 2);
        applyStimulus(2'b01, 16'h1000, 16'h0001, 8'h00, 1'b0);
        checkOutput("sub 1000-0001", 16'h0FFF, 1'b1, 3, 2);
        applyStimulus(2'b01, 16'h0000, 16'h0001, 8'h00, 1'b0);
        checkOutput("sub 0000-0001", 16'hFFFF, 1'b0, 3, 2);
        applyStimulus(2'b10, 16'h80C1, 16'hBEEF, 8'h00, 1'b0);
        checkOutput("shl 80C1", 16'h0182, 1'b1, 3, 2);
        applyStimulus(2'b11, 16'h0181, 16'h1234, 8'h00, 1'b0);
        checkOutput("shr 0181", 16'h00C0, 1'b1, 3, 2);
        applyStimulus(2'b00, 16'h1234, 16'h00F0, 8'b0000_1011, 1'b1);
        checkOutput("add with holds", 16'h1324, 1'b0, 6, 5);

        // Reset while SUB16 is in its second pass.
        @(posedge CLK); #2;
        start = 1'b1; CMD = 2'b01; A = 16'h5678; B = 16'h1234;
        @(posedge CLK); #2;
        start = 1'b0;
        @(posedge CLK); #2;
        reset = 1'b1;
        @(posedge CLK); #2;
        reset = 1'b0;
        @(negedge CLK);
        check("abort busy/done", {30'b0, busy, done}, 32'h0);
        check("abort RESULT", {15'b0, RESULT, CARRY_OUT}, 32'h0);
        check("abort drives", {9'b0, ALU_A, ALU_B, ALU_OP, ALU_FUNC, ALU_OVF_IN}, 32'h0);
        d0 = doneCount;
        repeat (5) @(negedge CLK);
        check("abort no done", doneCount - d0, 32'd0);
        applyStimulus(2'b00, 16'h0102, 16'h0304, 8'h00, 1'b0);
        checkOutput("add after abort", 16'h0406, 1'b0, 3, 2);

        for (int i = 0; i < 60; i++) begin
            logic [1:0]  rc;
            logic [15:0] ra, rb;
            logic [7:0]  rm;
            rc = 2'($urandom_range(0, 3));
            ra = 16'($urandom);
            rb = 16'($urandom);
            rm = 8'($urandom) & 8'($urandom);
            applyStimulus(rc, ra, rb, rm, bit'($urandom_range(0, 1)));
            check("random done count", lastDones, 32'd1);
        end

        repeat (3) @(posedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
